// File: rtl/reg_trace_monitor_if.sv
// Trace record stream: head record offered with valid/ready.
// Master drives records, slave consumes them.
interface reg_trace_monitor_if;
  logic        tr_valid;
  logic        tr_ready;
  logic [15:0] tr_data;

  modport master (
    output tr_valid,
    output tr_data,
    input  tr_ready
  );

  modport slave (
    input  tr_valid,
    input  tr_data,
    output tr_ready
  );
endinterface

// File: rtl/reg_trace_monitor.sv
// Register change tracer: snapshots regA/B/O, queues a seq-stamped
// record on each change into a FIFO, counts records lost to a full FIFO.
module reg_trace_monitor #(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       en,
  input  logic [3:0]                 regA,
  input  logic [3:0]                 regB,
  input  logic [3:0]                 regO,
  input  logic                       clr_ovf,
  reg_trace_monitor_if.master        tr,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level,
  output logic                       overflow,
  output logic [7:0]                 drop_cnt
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [15:0]   r_mem [DEPTH];
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [LW-1:0] r_level;
  logic [11:0]   r_snap;
  logic          r_snap_vld;
  logic [3:0]    r_seq;
  logic          r_ovf;
  logic [7:0]    r_drop;

  logic [11:0]   w_sample;
  logic          w_event;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;

  assign w_sample = {regA, regB, regO};
  assign w_event  = en && (!r_snap_vld || (w_sample != r_snap));
  assign w_full   = (r_level == LW'(DEPTH));
  assign w_pop    = tr.tr_valid && tr.tr_ready;
  // A pop in the same cycle frees the slot a full FIFO needs.
  assign w_push   = w_event && (!w_full || w_pop);
  assign w_drop   = w_event && w_full && !w_pop;

  assign tr.tr_valid = (r_level != '0);
  assign tr.tr_data  = tr.tr_valid ? r_mem[r_rd] : 16'h0000;
  assign fifo_level  = r_level;
  assign overflow    = r_ovf;
  assign drop_cnt    = r_drop;

  always_ff @(posedge clk) begin
    if (w_push && resetn) begin
      r_mem[r_wr] <= {r_seq, w_sample};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
    end else begin
      if (w_push) begin
        r_wr <= r_wr + PW'(1);
      end
      if (w_pop) begin
        r_rd <= r_rd + PW'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_snap     <= '0;
      r_snap_vld <= 1'b0;
      r_seq      <= '0;
    end else begin
      if (en) begin
        r_snap     <= w_sample;
        r_snap_vld <= 1'b1;
      end
      if (w_event) begin
        r_seq <= r_seq + 4'd1;
      end
    end
  end

  // A drop coinciding with a clear leaves exactly that one drop counted.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ovf  <= 1'b0;
      r_drop <= '0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
      if (clr_ovf) begin
        r_drop <= 8'd1;
      end else if (r_drop != 8'hFF) begin
        r_drop <= r_drop + 8'd1;
      end
    end else if (clr_ovf) begin
      r_ovf  <= 1'b0;
      r_drop <= '0;
    end
  end

endmodule

// File: tb/tb_reg_trace_monitor.sv
// Bench for reg_trace_monitor: vector table, corner sequences and
// random traffic against a queue-based record model.
module tb_reg_trace_monitor;

  logic       clk;
  logic       resetn;
  logic       en;
  logic [3:0] regA;
  logic [3:0] regB;
  logic [3:0] regO;
  logic       clr_ovf;
  logic [3:0] fifo_level;
  logic       overflow;
  logic [7:0] drop_cnt;

  reg_trace_monitor_if trif ();

  reg_trace_monitor #(.DEPTH(8)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .en         (en),
    .regA       (regA),
    .regB       (regB),
    .regO       (regO),
    .clr_ovf    (clr_ovf),
    .tr         (trif),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .drop_cnt   (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] m_q[$];
  logic [11:0] m_snap;
  bit          m_sv;
  int          m_seq;
  bit          m_ovf;
  int          m_drop;

  typedef struct {
    logic        en;
    logic [3:0]  a;
    logic [3:0]  b;
    logic [3:0]  o;
    logic        rdy;
    logic        clr;
    logic        ev;
    logic [15:0] ed;
    int          el;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_snap = '0;
    m_sv   = 1'b0;
    m_seq  = 0;
    m_ovf  = 1'b0;
    m_drop = 0;
  endtask

  task automatic chk_model(input string name);
    chk({name, ".valid"}, int'(trif.tr_valid), (m_q.size() > 0) ? 1 : 0);
    chk({name, ".data"}, int'(trif.tr_data),
        (m_q.size() > 0) ? int'(m_q[0]) : 0);
    chk({name, ".level"}, int'(fifo_level), m_q.size());
    chk({name, ".ovf"}, int'(overflow), int'(m_ovf));
    chk({name, ".drop"}, int'(drop_cnt), m_drop);
  endtask

  // Called at the falling edge: apply inputs, advance model, clock once.
  task automatic cyc(input logic e, input logic [3:0] a, input logic [3:0] b,
                     input logic [3:0] o, input logic rdy, input logic clr);
    logic [11:0] s;
    bit pop, evt, room;
    en = e; regA = a; regB = b; regO = o;
    trif.tr_ready = rdy; clr_ovf = clr;
    s    = {a, b, o};
    pop  = (m_q.size() > 0) && rdy;
    evt  = e && (!m_sv || s != m_snap);
    room = (m_q.size() < 8) || pop;
    if (e) begin
      m_snap = s;
      m_sv   = 1'b1;
    end
    if (pop) void'(m_q.pop_front());
    if (evt && !room) begin
      m_ovf  = 1'b1;
      m_drop = clr ? 1 : ((m_drop < 255) ? m_drop + 1 : 255);
    end else if (clr) begin
      m_ovf  = 1'b0;
      m_drop = 0;
    end
    if (evt && room) m_q.push_back({4'(m_seq), s});
    if (evt) m_seq = (m_seq + 1) % 16;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    en = 1'b0; clr_ovf = 1'b0; trif.tr_ready = 1'b0;
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    logic [15:0] held;
    resetn = 1'b0;
    en = 1'b0; regA = '0; regB = '0; regO = '0;
    clr_ovf = 1'b0; trif.tr_ready = 1'b0;
    model_reset();

    tbl[0] = '{1'b1, 4'h3, 4'h5, 4'h0, 1'b1, 1'b0, 1'b1, 16'h0350, 1};
    tbl[1] = '{1'b1, 4'h3, 4'h5, 4'h0, 1'b1, 1'b0, 1'b0, 16'h0000, 0};
    tbl[2] = '{1'b1, 4'h3, 4'h5, 4'h0, 1'b1, 1'b0, 1'b0, 16'h0000, 0};
    tbl[3] = '{1'b1, 4'h3, 4'h5, 4'h1, 1'b0, 1'b0, 1'b1, 16'h1351, 1};
    tbl[4] = '{1'b1, 4'h3, 4'h5, 4'h2, 1'b0, 1'b0, 1'b1, 16'h1351, 2};
    tbl[5] = '{1'b0, 4'h3, 4'h5, 4'h7, 1'b1, 1'b0, 1'b1, 16'h2352, 1};
    tbl[6] = '{1'b0, 4'h3, 4'h5, 4'h7, 1'b1, 1'b0, 1'b0, 16'h0000, 0};
    tbl[7] = '{1'b1, 4'h3, 4'h5, 4'h2, 1'b1, 1'b0, 1'b0, 16'h0000, 0};
    tbl[8] = '{1'b1, 4'h3, 4'h5, 4'h7, 1'b0, 1'b0, 1'b1, 16'h3357, 1};
    tbl[9] = '{1'b1, 4'h3, 4'h5, 4'h7, 1'b0, 1'b1, 1'b1, 16'h3357, 1};

    @(negedge clk);
    chk("rst.valid", int'(trif.tr_valid), 0);
    chk("rst.data", int'(trif.tr_data), 0);
    chk("rst.level", int'(fifo_level), 0);
    chk("rst.ovf", int'(overflow), 0);
    chk("rst.drop", int'(drop_cnt), 0);
    resetn = 1'b1;

    for (int i = 0; i < 10; i++) begin
      cyc(tbl[i].en, tbl[i].a, tbl[i].b, tbl[i].o, tbl[i].rdy, tbl[i].clr);
      chk($sformatf("vec%0d.valid", i), int'(trif.tr_valid), int'(tbl[i].ev));
      chk($sformatf("vec%0d.data", i), int'(trif.tr_data), int'(tbl[i].ed));
      chk($sformatf("vec%0d.level", i), int'(fifo_level), tbl[i].el);
    end

    do_reset();
    for (int i = 0; i < 9; i++) cyc(1'b1, 4'h0, 4'h0, 4'(i), 1'b0, 1'b0);
    chk("ovf9.level", int'(fifo_level), 8);
    chk("ovf9.ovf", int'(overflow), 1);
    chk("ovf9.drop", int'(drop_cnt), 1);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain%0d.seq", i), int'(trif.tr_data[15:12]), i);
      cyc(1'b0, 4'h0, 4'h0, 4'h8, 1'b1, 1'b0);
    end
    chk("drain.empty", int'(trif.tr_valid), 0);
    cyc(1'b1, 4'h0, 4'h0, 4'h9, 1'b1, 1'b0);
    chk("gap.seq", int'(trif.tr_data[15:12]), 9);
    chk_model("gap");

    do_reset();
    for (int i = 0; i < 8; i++) cyc(1'b1, 4'h1, 4'h0, 4'(i), 1'b0, 1'b0);
    cyc(1'b1, 4'h1, 4'h0, 4'h8, 1'b1, 1'b0);
    chk("fullpop.level", int'(fifo_level), 8);
    chk("fullpop.ovf", int'(overflow), 0);
    chk("fullpop.drop", int'(drop_cnt), 0);
    for (int i = 9; i < 270; i++) cyc(1'b1, 4'h1, 4'h0, 4'(i), 1'b0, 1'b0);
    chk("sat.drop", int'(drop_cnt), 255);
    chk_model("sat");
    cyc(1'b1, 4'h1, 4'h0, 4'hF, 1'b0, 1'b1);
    chk("clrdrop.ovf", int'(overflow), 1);
    chk("clrdrop.drop", int'(drop_cnt), 1);
    cyc(1'b0, 4'h1, 4'h0, 4'h3, 1'b0, 1'b1);
    chk("clr.ovf", int'(overflow), 0);
    chk("clr.drop", int'(drop_cnt), 0);

    do_reset();
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 4'h2, 4'h4, 4'(i), 1'b1, 1'b0);
      chk($sformatf("wrap%0d.seq", i), int'(trif.tr_data[15:12]), i % 16);
    end
    held = trif.tr_data;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 4'h2, 4'h4, 4'h0, 1'b0, 1'b0);
      chk($sformatf("stall%0d.data", i), int'(trif.tr_data), int'(held));
    end

    do_reset();
    for (int i = 1; i <= 5; i++) cyc(1'b1, 4'h0, 4'h0, 4'(i), 1'b0, 1'b0);
    chk("q5.level", int'(fifo_level), 5);
    #2 resetn = 1'b0;
    #1;
    chk("async.valid", int'(trif.tr_valid), 0);
    chk("async.level", int'(fifo_level), 0);
    chk("async.data", int'(trif.tr_data), 0);
    model_reset();
    @(negedge clk);
    en = 1'b1; trif.tr_ready = 1'b1;
    @(negedge clk);
    chk("inrst.level", int'(fifo_level), 0);
    resetn = 1'b1;
    cyc(1'b1, 4'hA, 4'hB, 4'hC, 1'b0, 1'b0);
    chk("post.data", int'(trif.tr_data), 16'h0ABC);

    do_reset();
    for (int i = 0; i < 1500; i++) begin
      cyc($urandom_range(0, 9) != 0, 4'($urandom_range(0, 1)),
          4'($urandom_range(0, 1)), 4'($urandom_range(0, 2)),
          (i % 200 < 100) ? ($urandom_range(0, 3) == 0)
                          : ($urandom_range(0, 3) != 0),
          $urandom_range(0, 19) == 0);
      chk_model($sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_trace_monitor.md
REG_TRACE_MONITOR -- requirements
Module: reg_trace_monitor

Interface
REQ-001 Parameter: DEPTH, 8, trace FIFO entries (power of two, 2..64).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: resetn  input  1  reset, asynchronous, active-low.
REQ-004 Port: en  input  1  sampling enable; while 0, no change detection and no records.
REQ-005 Port: regA  input  4  core register A, sampled each enabled clock.
REQ-006 Port: regB  input  4  core register B, sampled each enabled clock.
REQ-007 Port: regO  input  4  core output register, sampled each enabled clock.
REQ-008 Port: tr_valid  output  1  FIFO head holds a record.
REQ-009 Port: tr_ready  input  1  consumer accepts head record.
REQ-010 Port: tr_data  output  16  head record {seq[3:0], regA, regB, regO}, seq in [15:12].
REQ-011 Port: fifo_level  output  $clog2(DEPTH+1)  occupied entries.
REQ-012 Port: overflow  output  1  sticky: a record was dropped because the FIFO was full.
REQ-013 Port: drop_cnt  output  8  dropped records, saturating.
REQ-014 Port: clr_ovf  input  1  synchronous clear of overflow and drop_cnt.

Function
REQ-015 Snapshot register holds last sampled {regA,regB,regO} plus a snap_valid flag.
REQ-016 Change event: en=1 and (snap_valid=0 or sampled 12-bit value != snapshot).
REQ-017 On every enabled edge, snapshot loads sampled value and snap_valid sets to 1, whether or not an event occurs or is dropped.
REQ-018 seq counter (4 bits) stamps each event with its current value, then increments modulo 16 (15 -> 0); increments on dropped events too, so consumers detect gaps.
REQ-019 Event with FIFO not full, or full with pop in the same cycle: record written at tail.
REQ-020 Event with FIFO full and no pop in the same cycle: record dropped, overflow set, drop_cnt incremented, holding at 255.
REQ-021 Latency: inputs sampled at edge N produce a record visible at tr_data/tr_valid after edge N when FIFO was empty; no combinational bypass from regX to tr_data.
REQ-022 tr_valid = (fifo_level != 0); tr_data = head entry, stable while tr_valid=1 and tr_ready=0.
REQ-023 Pop when tr_valid=1 and tr_ready=1; tr_ready with tr_valid=0 has no effect.
REQ-024 Simultaneous push and pop: level unchanged, both accepted, at any level including empty-to-nonempty ordering (push when empty with no pop: level 0 -> 1).
REQ-025 Pointers wrap modulo DEPTH; FIFO is first-in first-out with no reordering.
REQ-026 clr_ovf=1 clears overflow and drop_cnt; a drop in the same cycle wins: overflow=1, drop_cnt=1.
REQ-027 en falling to 0 keeps snapshot and snap_valid; on re-enable, comparison uses the held snapshot.
REQ-028 FIFO drains normally while en=0.

Reset
REQ-029 resetn=0 immediately forces: FIFO empty, fifo_level=0, tr_valid=0, tr_data=0, overflow=0, drop_cnt=0, seq=0, snap_valid=0, snapshot=0.
REQ-030 Reset asserted mid-operation discards all queued records; first enabled edge after release always produces an event with seq=0.
REQ-031 No state changes while resetn=0, regardless of en, tr_ready, or clr_ovf.

Verification
REQ-032 Reset release, en=1, regs A=3 B=5 O=0 constant, tr_ready=1 -> exactly one record 0x0350, then tr_valid=0 thereafter.
REQ-033 tr_ready=0, regO changes on 9 consecutive cycles (DEPTH=8) -> fifo_level=8, overflow=1, drop_cnt=1; drained records carry seq 0..7, the next accepted record carries seq 9.
REQ-034 FIFO full, new event with tr_ready=1 in the same cycle -> no drop, level stays 8, overflow stays 0.
REQ-035 20 changes with tr_ready=1 -> seq wraps 15 -> 0 -> 1 ... with no gaps; tr_data held stable across tr_ready stalls.
REQ-036 drop_cnt at 255 plus further drops -> stays 255; clr_ovf with a coincident drop -> overflow=1, drop_cnt=1.
REQ-037 resetn pulsed low with 5 queued records -> tr_valid=0 and level=0 asynchronously; after release, the first record is 0x0xxx with seq=0.
